// File: rtl/qsn_shift_sequencer.sv
// qsn_shift_sequencer: walks the base-matrix shift table layer-major and
// feeds shift_factor plus layer/col tags to the QSN permuter.
//
// Ports:
//   sys_clk, rst            clock, synchronous active-high reset
//   tbl_wr_en/addr/data     table write port, {nonzero flag, shift}
//   start, hold             begin a pass / stall issue
//   shift_factor            registered shift to the permuter
//   issue_valid/layer/col   entry currently presented to the permuter
//   out_valid/layer/col     tags re-aligned with the permuter output
//   busy, done, cfg_err     pass status and sticky bad-shift flag
module qsn_shift_sequencer #(
  parameter int PERMUTATION_LENGTH = 765,
  parameter int PIPELINE_STAGES    = 4,
  parameter int ROW_NUM            = 3,
  parameter int COL_NUM            = 17,
  parameter int SHIFT_W            = 10,
  parameter int LAYER_W            = 2,
  parameter int COL_W              = 5,
  parameter int ADDR_W             = 6
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               tbl_wr_en,
  input  logic [ADDR_W-1:0]  tbl_wr_addr,
  input  logic [SHIFT_W:0]   tbl_wr_data,
  input  logic               start,
  input  logic               hold,
  output logic [SHIFT_W-1:0] shift_factor,
  output logic               issue_valid,
  output logic [LAYER_W-1:0] issue_layer,
  output logic [COL_W-1:0]   issue_col,
  output logic               out_valid,
  output logic [LAYER_W-1:0] out_layer,
  output logic [COL_W-1:0]   out_col,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int ENTRIES = ROW_NUM * COL_NUM;
  localparam int DCNT_W  = $clog2(PIPELINE_STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SHIFT_W:0] tbl [ENTRIES];

  logic [LAYER_W-1:0] layer_q;
  logic [COL_W-1:0]   col_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DCNT_W-1:0]  dcnt_q;

  logic [SHIFT_W-1:0] shift_q;
  logic               ivalid_q;
  logic [LAYER_W-1:0] ilayer_q;
  logic [COL_W-1:0]   icol_q;
  logic               busy_q;
  logic               cfg_err_q;

  logic               dl_v [PIPELINE_STAGES];
  logic [LAYER_W-1:0] dl_l [PIPELINE_STAGES];
  logic [COL_W-1:0]   dl_c [PIPELINE_STAGES];

  logic               wr_hit;
  logic               wr_shift_ok;
  logic               wr_accept;
  logic               wr_reject;
  logic [SHIFT_W:0]   rd_entry;
  logic               rd_nonzero;
  logic [SHIFT_W-1:0] rd_shift;
  logic               last_col;
  logic               last_entry;
  logic               issue_fire;

  // Table write qualification. Out-of-range addresses are silently
  // dropped; only an in-range write with an illegal shift flags cfg_err.
  always_comb begin
    wr_hit      = tbl_wr_en && (state_q == S_IDLE)
                  && (tbl_wr_addr < ADDR_W'(ENTRIES));
    wr_shift_ok = tbl_wr_data[SHIFT_W-1:0]
                  < SHIFT_W'(PERMUTATION_LENGTH);
    wr_accept   = wr_hit && wr_shift_ok;
    wr_reject   = wr_hit && !wr_shift_ok;
  end

  // Table storage survives rst on purpose.
  always_ff @(posedge sys_clk) begin
    if (wr_accept) begin
      tbl[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  always_comb begin
    rd_entry   = tbl[addr_q];
    rd_nonzero = rd_entry[SHIFT_W];
    rd_shift   = rd_entry[SHIFT_W-1:0];
    last_col   = (col_q == COL_W'(COL_NUM - 1));
    last_entry = last_col && (layer_q == LAYER_W'(ROW_NUM - 1));
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN spans PIPELINE_STAGES+1 cycles so that DONE lines up with the
  // cycle after the last aligned output slot.
  always_comb begin
    state_d    = state_q;
    issue_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!hold) begin
          issue_fire = 1'b1;
          if (last_entry) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DCNT_W'(PIPELINE_STAGES)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Walk counters and issue registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      layer_q  <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      dcnt_q   <= '0;
      shift_q  <= '0;
      ivalid_q <= 1'b0;
      ilayer_q <= '0;
      icol_q   <= '0;
    end else begin
      ivalid_q <= 1'b0;
      if (state_q == S_IDLE && start) begin
        layer_q <= '0;
        col_q   <= '0;
        addr_q  <= '0;
      end
      if (state_q == S_DRAIN) begin
        dcnt_q <= dcnt_q + 1'b1;
      end else begin
        dcnt_q <= '0;
      end
      if (issue_fire) begin
        ilayer_q <= layer_q;
        icol_q   <= col_q;
        // Null submatrices consume a slot but keep the old shift.
        if (rd_nonzero) begin
          shift_q  <= rd_shift;
          ivalid_q <= 1'b1;
        end
        // Counters park on the last entry so the table read stays in range.
        if (!last_entry) begin
          addr_q <= addr_q + 1'b1;
          if (last_col) begin
            col_q   <= '0;
            layer_q <= layer_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
      end
    end
  end

  // busy covers the issue cycles and all but the final DRAIN cycle, which
  // makes it drop exactly when done rises.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      busy_q <= (state_q == S_ISSUE)
                || (state_q == S_DRAIN && state_d == S_DRAIN);
      if (wr_reject) cfg_err_q <= 1'b1;
    end
  end

  // Tag delay line: shifts every cycle, bubbles included.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < PIPELINE_STAGES; i++) begin
        dl_v[i] <= 1'b0;
        dl_l[i] <= '0;
        dl_c[i] <= '0;
      end
    end else begin
      dl_v[0] <= ivalid_q;
      dl_l[0] <= ilayer_q;
      dl_c[0] <= icol_q;
      for (int i = 1; i < PIPELINE_STAGES; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_l[i] <= dl_l[i-1];
        dl_c[i] <= dl_c[i-1];
      end
    end
  end

  assign shift_factor = shift_q;
  assign issue_valid  = ivalid_q;
  assign issue_layer  = ilayer_q;
  assign issue_col    = icol_q;
  assign out_valid    = dl_v[PIPELINE_STAGES-1];
  assign out_layer    = dl_l[PIPELINE_STAGES-1];
  assign out_col      = dl_c[PIPELINE_STAGES-1];
  assign busy         = busy_q;
  assign done         = (state_q == S_DONE);
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_qsn_shift_sequencer.sv
// tb_qsn_shift_sequencer: scoreboard bench for qsn_shift_sequencer.
// Directed passes push expected issue/output/done events; a monitor pops.
module tb_qsn_shift_sequencer;

  localparam int N = 51;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tbl_wr_en;
  logic [5:0] tbl_wr_addr;
  logic [10:0] tbl_wr_data;
  logic       start;
  logic       hold;
  logic [9:0] shift_factor;
  logic       issue_valid;
  logic [1:0] issue_layer;
  logic [4:0] issue_col;
  logic       out_valid;
  logic [1:0] out_layer;
  logic [4:0] out_col;
  logic       busy;
  logic       done;
  logic       cfg_err;

  always #5 clk = ~clk;

  qsn_shift_sequencer dut (
    .sys_clk      (clk),
    .rst          (rst),
    .tbl_wr_en    (tbl_wr_en),
    .tbl_wr_addr  (tbl_wr_addr),
    .tbl_wr_data  (tbl_wr_data),
    .start        (start),
    .hold         (hold),
    .shift_factor (shift_factor),
    .issue_valid  (issue_valid),
    .issue_layer  (issue_layer),
    .issue_col    (issue_col),
    .out_valid    (out_valid),
    .out_layer    (out_layer),
    .out_col      (out_col),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  typedef struct {
    int c;
    int lay;
    int col;
    int sh;
  } ev_t;

  ev_t iq[$];
  ev_t oq[$];
  int  dq[$];
  int  mf[N];
  int  ms[N];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  hlo = -1;
  int  hhi = -1;
  int  busy_cnt = 0;
  int  exp_busy = 0;
  int  last_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (busy) busy_cnt++;
    if (issue_valid) begin
      if (iq.size() == 0) chk("issue_extra", cyc, -1);
      else begin
        e = iq.pop_front();
        chk("issue_cyc", cyc, e.c);
        chk("issue_shift", int'(shift_factor), e.sh);
        chk("issue_layer", int'(issue_layer), e.lay);
        chk("issue_col", int'(issue_col), e.col);
      end
    end
    if (out_valid) begin
      if (oq.size() == 0) chk("out_extra", cyc, -1);
      else begin
        e = oq.pop_front();
        chk("out_cyc", cyc, e.c);
        chk("out_layer", int'(out_layer), e.lay);
        chk("out_col", int'(out_col), e.col);
      end
    end
    if (done) begin
      last_done = cyc;
      if (dq.size() == 0) chk("done_extra", cyc, -1);
      else chk("done_cyc", cyc, dq.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    hold = (cyc + 1 >= hlo) && (cyc + 1 <= hhi);
  endtask

  task automatic step_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wr(input int a, input int f, input int s);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 6'(a);
    tbl_wr_data = {1'(f), 10'(s)};
    tick();
    tbl_wr_en = 1'b0;
    if (a < N && s < 765) begin
      mf[a] = f;
      ms[a] = s;
    end
  endtask

  task automatic expect_pass(input int t);
    int e;
    int k;
    e = t + 1;
    k = 0;
    while (k < N) begin
      if (!(e >= hlo && e <= hhi)) begin
        if (mf[k] != 0) begin
          iq.push_back('{e, k / 17, k % 17, ms[k]});
          oq.push_back('{e + P, k / 17, k % 17, 0});
        end
        k++;
      end
      e++;
    end
    dq.push_back(e + P);
    exp_busy = e - 1 + P - t;
  endtask

  task automatic begin_pass(input int hl, input int hh, output int t);
    start = 1'b1;
    t = cyc + 1;
    if (hl >= 0) begin
      hlo = t + hl;
      hhi = t + hh;
    end else begin
      hlo = -1;
      hhi = -1;
    end
    busy_cnt = 0;
    expect_pass(t);
    tick();
    start = 1'b0;
  endtask

  task automatic end_pass(input int t);
    step_to(t + exp_busy + 3);
    hlo = -1;
    hhi = -1;
    chk("issue_left", iq.size(), 0);
    chk("out_left", oq.size(), 0);
    chk("done_left", dq.size(), 0);
    chk("busy_cycles", busy_cnt, exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    tbl_wr_en = 1'b0;
    tbl_wr_addr = '0;
    tbl_wr_data = '0;
    for (int i = 0; i < N; i++) begin
      mf[i] = 0;
      ms[i] = 0;
    end
    repeat (3) tick();
    chk("rst_shift", int'(shift_factor), 0);
    chk("rst_ivalid", int'(issue_valid), 0);
    chk("rst_icol", int'(issue_col), 0);
    chk("rst_ovalid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    rst = 1'b0;
    tick();

    // out-of-range addresses never raise cfg_err
    wr(51, 1, 1000);
    wr(63, 1, 5);
    tick();
    chk("oor_no_err", int'(cfg_err), 0);

    // basic pass
    for (int a = 0; a < N; a++) wr(a, 1, a * 13);
    tick();
    begin_pass(-1, -1, t);
    step_to(t + 1);
    chk("basic_sf0", int'(shift_factor), 0);
    step_to(t + 5);
    chk("basic_out0_v", int'(out_valid), 1);
    chk("basic_out0_col", int'(out_col), 0);
    step_to(t + 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    step_to(t + 51);
    chk("basic_sf_last", int'(shift_factor), 650);
    chk("basic_col_last", int'(issue_col), 16);
    end_pass(t);
    chk("basic_done_at", last_done, t + 56);
    chk("basic_busy55", busy_cnt, 55);

    // null entries, plus start in the done cycle
    wr(5, 0, 65);
    wr(50, 0, 650);
    tick();
    begin_pass(-1, -1, t);
    step_to(t + 6);
    chk("null5_iv", int'(issue_valid), 0);
    chk("null5_sf", int'(shift_factor), 52);
    chk("null5_col", int'(issue_col), 5);
    step_to(t + 10);
    chk("null5_ov", int'(out_valid), 0);
    step_to(t + 51);
    chk("null50_iv", int'(issue_valid), 0);
    chk("null50_sf", int'(shift_factor), 637);
    step_to(t + 55);
    chk("null50_ov", int'(out_valid), 0);
    step_to(t + 56);
    chk("null_done", int'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    step_to(t + 58);
    chk("done_start_ign", int'(busy), 0);
    end_pass(t);

    // hold for three cycles
    wr(5, 1, 65);
    wr(50, 1, 650);
    tick();
    begin_pass(3, 5, t);
    step_to(t + 2);
    chk("hold_e1_col", int'(issue_col), 1);
    step_to(t + 4);
    chk("hold_iv", int'(issue_valid), 0);
    chk("hold_sf", int'(shift_factor), 13);
    chk("hold_col", int'(issue_col), 1);
    step_to(t + 6);
    chk("hold_e2_col", int'(issue_col), 2);
    chk("hold_e2_sf", int'(shift_factor), 26);
    step_to(t + 8);
    chk("hold_bubble", int'(out_valid), 0);
    end_pass(t);
    chk("hold_done_at", last_done, t + 59);

    // write while busy is ignored
    begin_pass(-1, -1, t);
    step_to(t + 10);
    tbl_wr_en = 1'b1;
    tbl_wr_addr = 6'd1;
    tbl_wr_data = {1'b1, 10'd500};
    tick();
    tbl_wr_en = 1'b0;
    end_pass(t);

    // write and start together: pass sees the new value
    tbl_wr_en = 1'b1;
    tbl_wr_addr = 6'd2;
    tbl_wr_data = {1'b1, 10'd7};
    mf[2] = 1;
    ms[2] = 7;
    begin_pass(-1, -1, t);
    tbl_wr_en = 1'b0;
    step_to(t + 2);
    chk("gate_old_sf", int'(shift_factor), 13);
    step_to(t + 3);
    chk("wr_start_sf", int'(shift_factor), 7);
    end_pass(t);

    // config errors
    wr(0, 1, 765);
    tick();
    chk("cfg_err_set", int'(cfg_err), 1);
    wr(0, 1, 764);
    tick();
    chk("cfg_err_keep", int'(cfg_err), 1);
    begin_pass(-1, -1, t);
    step_to(t + 1);
    chk("cfg_764_sf", int'(shift_factor), 764);
    end_pass(t);
    chk("cfg_err_sticky", int'(cfg_err), 1);

    // abort and restart
    begin_pass(-1, -1, t);
    step_to(t + 19);
    rst = 1'b1;
    tick();
    chk("abort_sf", int'(shift_factor), 0);
    chk("abort_iv", int'(issue_valid), 0);
    chk("abort_il", int'(issue_layer), 0);
    chk("abort_ic", int'(issue_col), 0);
    chk("abort_ov", int'(out_valid), 0);
    chk("abort_ol", int'(out_layer), 0);
    chk("abort_oc", int'(out_col), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_cfg_err", int'(cfg_err), 0);
    iq.delete();
    oq.delete();
    dq.delete();
    rst = 1'b0;
    step_to(t + 40);
    chk("abort_idle", int'(busy), 0);
    begin_pass(-1, -1, t);
    step_to(t + 1);
    chk("restart_sf0", int'(shift_factor), 764);
    end_pass(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
